// File: rtl/music_note_sequencer.sv
// Music memory reader: rewinds, fetches one entry at a time, and holds
// each decoded note on the tone interface for its beat length.
module music_note_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int NOTE_WIDTH     = 5,
  parameter int MAX_DEPTH_BIT  = 8,
  parameter int BEAT_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 2500000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  output logic                     mem_read_en,
  output logic                     mem_read_rst,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     mem_output_ready,
  input  logic [MAX_DEPTH_BIT-1:0] mem_duration,
  output logic [NOTE_WIDTH-1:0]    note_out,
  output logic                     note_valid,
  output logic [MAX_DEPTH_BIT-1:0] note_index,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int LEN_WIDTH = DATA_WIDTH - NOTE_WIDTH;
  localparam logic [NOTE_WIDTH-1:0] END_MARK = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]              cnt;
  logic [31:0]              play_len;
  logic [LEN_WIDTH-1:0]     len;
  logic [NOTE_WIDTH-1:0]    mem_note;
  logic [LEN_WIDTH-1:0]     mem_len;
  logic [MAX_DEPTH_BIT-1:0] idx_next;
  logic play_last, gap_last, wait_last;
  logic counting, held;

  assign mem_note  = mem_data[DATA_WIDTH-1 -: NOTE_WIDTH];
  assign mem_len   = mem_data[LEN_WIDTH-1:0];
  assign idx_next  = note_index + MAX_DEPTH_BIT'(1);
  assign play_len  = (32'(len) + 32'd1) * 32'(BEAT_CYCLES);
  assign play_last = (cnt == play_len - 32'd1);
  assign gap_last  = (cnt == 32'(GAP_CYCLES) - 32'd1);
  assign wait_last = (cnt == 32'(TIMEOUT_CYCLES) - 32'd1);
  assign counting  = (state == S_WAIT) || (state == S_PLAY) ||
                     (state == S_GAP);
  assign held      = pause && ((state == S_PLAY) || (state == S_GAP));

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nx = S_REWIND;
        S_REWIND: state_nx = (mem_duration == '0) ? S_DONE : S_FETCH;
        S_FETCH:  state_nx = S_WAIT;
        S_WAIT: begin
          if (mem_output_ready)
            state_nx = (mem_note == END_MARK) ? S_DONE : S_PLAY;
          else if (wait_last)
            state_nx = S_DONE;
        end
        S_PLAY: begin
          if (!pause && play_last) begin
            if (idx_next == mem_duration) state_nx = S_DONE;
            else if (GAP_CYCLES == 0)     state_nx = S_FETCH;
            else                          state_nx = S_GAP;
          end
        end
        S_GAP:    if (!pause && gap_last) state_nx = S_FETCH;
        S_DONE:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len        <= '0;
      note_out   <= '0;
      note_index <= '0;
      error      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state)     cnt <= '0;
      else if (counting && !held) cnt <= cnt + 32'd1;
      if (state == S_IDLE && start && !stop) begin
        note_index <= '0;
        error      <= 1'b0;
      end
      if (state == S_WAIT && mem_output_ready && !stop) begin
        note_out <= mem_note;
        len      <= mem_len;
      end
      if (state == S_WAIT && !mem_output_ready && wait_last && !stop)
        error <= 1'b1;
      if (state == S_PLAY && !pause && play_last && !stop)
        note_index <= idx_next;
      // tone code is dropped whenever the song ends or is aborted
      if (state_nx == S_DONE || state_nx == S_IDLE)
        note_out <= '0;
    end
  end

  assign note_valid   = (state == S_PLAY) && !pause && (note_out != '0);
  assign mem_read_rst = (state == S_REWIND);
  assign mem_read_en  = (state == S_FETCH);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

endmodule
